// File: rtl/mem_arbiter_if.sv
// Request, response and block-memory signals of the two-port memory arbiter.
// The arbiter takes the slave side; the core and the memory take the master side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              P0_VALID;
    logic              P0_READY;
    logic [31:0]       P0_ADDR;
    logic              P0_WE;
    logic [31:0]       P0_WDATA;
    logic [3:0]        P0_WSTRB;

    logic              P1_VALID;
    logic              P1_READY;
    logic [31:0]       P1_ADDR;
    logic              P1_WE;
    logic [31:0]       P1_WDATA;
    logic [3:0]        P1_WSTRB;

    logic              P0_RSP_VALID;
    logic              P1_RSP_VALID;
    logic [31:0]       RSP_DATA;

    logic              MEM_ENABLED;
    logic [ADDR_W-1:0] ADDRESS;
    logic              WRITE_ENABLE;
    logic [31:0]       WRITE_DATA;
    logic [31:0]       READ_DATA;

    modport slave (
        input  P0_VALID, P0_ADDR, P0_WE, P0_WDATA, P0_WSTRB,
        input  P1_VALID, P1_ADDR, P1_WE, P1_WDATA, P1_WSTRB,
        input  READ_DATA,
        output P0_READY, P1_READY,
        output P0_RSP_VALID, P1_RSP_VALID, RSP_DATA,
        output MEM_ENABLED, ADDRESS, WRITE_ENABLE, WRITE_DATA
    );

    modport master (
        output P0_VALID, P0_ADDR, P0_WE, P0_WDATA, P0_WSTRB,
        output P1_VALID, P1_ADDR, P1_WE, P1_WDATA, P1_WSTRB,
        output READ_DATA,
        input  P0_READY, P1_READY,
        input  P0_RSP_VALID, P1_RSP_VALID, RSP_DATA,
        input  MEM_ENABLED, ADDRESS, WRITE_ENABLE, WRITE_DATA
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a 1-cycle-read block memory.
// Partial-word stores are sequenced as a read followed by a merged full-word write.
module mem_arbiter #(
    parameter int ADDR_W = 10
) (
    input  logic         CLK,
    input  logic         RST,
    mem_arbiter_if.slave bus
);

    typedef enum logic {ACCEPT, RMW_WR} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    req_t              req [2];
    req_t              gr;
    logic [1:0]        vld;
    logic              gnt_port;
    logic [1:0]        ready;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       merged;
    logic              unused_addr_bits;

    state_t            state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic [1:0]        rsp_vld_q, rsp_vld_d;
    logic              rsp_rd_q, rsp_rd_d;
    logic [ADDR_W-1:0] rmw_addr_q, rmw_addr_d;
    logic [31:0]       rmw_wdata_q, rmw_wdata_d;
    logic [3:0]        rmw_wstrb_q, rmw_wstrb_d;
    logic              rmw_port_q, rmw_port_d;

    assign req[0] = {bus.P0_ADDR, bus.P0_WE, bus.P0_WDATA, bus.P0_WSTRB};
    assign req[1] = {bus.P1_ADDR, bus.P1_WE, bus.P1_WDATA, bus.P1_WSTRB};
    assign vld    = {bus.P1_VALID, bus.P0_VALID};

    // Round-robin only matters on conflict; a lone requester always wins.
    assign gnt_port = (&vld) ? ~last_gnt_q : vld[1];
    assign gr       = req[gnt_port];

    // Only the word-address bits reach the memory.
    assign unused_addr_bits = ^{gr.addr[31:ADDR_W+2], gr.addr[1:0]};

    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign merged[8*b +: 8] = rmw_wstrb_q[b] ? rmw_wdata_q[8*b +: 8]
                                                 : bus.READ_DATA[8*b +: 8];
    end

    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        rsp_vld_d   = '0;
        rsp_rd_d    = 1'b0;
        rmw_addr_d  = rmw_addr_q;
        rmw_wdata_d = rmw_wdata_q;
        rmw_wstrb_d = rmw_wstrb_q;
        rmw_port_d  = rmw_port_q;
        ready       = '0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = gr.addr[ADDR_W+1:2];
        mem_wdata   = gr.wdata;

        case (state_q)
            ACCEPT: begin
                if (!RST && (|vld)) begin
                    ready[gnt_port] = 1'b1;
                    last_gnt_d      = gnt_port;
                    if (!gr.we) begin
                        mem_en              = 1'b1;
                        rsp_vld_d[gnt_port] = 1'b1;
                        rsp_rd_d            = 1'b1;
                    end else if (gr.wstrb == 4'hF) begin
                        mem_en              = 1'b1;
                        mem_we              = 1'b1;
                        rsp_vld_d[gnt_port] = 1'b1;
                    end else if (gr.wstrb == 4'h0) begin
                        rsp_vld_d[gnt_port] = 1'b1;
                    end else begin
                        // Fetch the old word now; the merge happens next cycle.
                        mem_en      = 1'b1;
                        rmw_addr_d  = gr.addr[ADDR_W+1:2];
                        rmw_wdata_d = gr.wdata;
                        rmw_wstrb_d = gr.wstrb;
                        rmw_port_d  = gnt_port;
                        state_d     = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                mem_en                = 1'b1;
                mem_we                = 1'b1;
                mem_addr              = rmw_addr_q;
                mem_wdata             = merged;
                rsp_vld_d[rmw_port_q] = 1'b1;
                state_d               = ACCEPT;
            end
            default: state_d = ACCEPT;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ACCEPT;
            last_gnt_q  <= 1'b1;
            rsp_vld_q   <= '0;
            rsp_rd_q    <= 1'b0;
            rmw_addr_q  <= '0;
            rmw_wdata_q <= '0;
            rmw_wstrb_q <= '0;
            rmw_port_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_rd_q    <= rsp_rd_d;
            rmw_addr_q  <= rmw_addr_d;
            rmw_wdata_q <= rmw_wdata_d;
            rmw_wstrb_q <= rmw_wstrb_d;
            rmw_port_q  <= rmw_port_d;
        end
    end

    assign bus.P0_READY     = ready[0];
    assign bus.P1_READY     = ready[1];
    assign bus.P0_RSP_VALID = rsp_vld_q[0];
    assign bus.P1_RSP_VALID = rsp_vld_q[1];
    // Write responses carry zero; read data comes straight off the memory.
    assign bus.RSP_DATA     = rsp_rd_q ? bus.READ_DATA : '0;
    assign bus.MEM_ENABLED  = mem_en;
    assign bus.WRITE_ENABLE = mem_we;
    assign bus.ADDRESS      = mem_addr;
    assign bus.WRITE_DATA   = mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and random checks of mem_arbiter against a transaction-level model:
// a word array updated at acceptance plus a queue of expected responses.
module tb_mem_arbiter;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic mem_clr = 1'b0;

    always #5 CLK = ~CLK;

    mem_arbiter_if #(.ADDR_W(10)) bus ();
    mem_arbiter #(.ADDR_W(10)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    // Block memory: registered read (old data on a same-cycle write), word write.
    logic [31:0] mem [1024];
    always @(posedge CLK) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i[9:0]] <= '0;
        end else if (bus.MEM_ENABLED) begin
            bus.READ_DATA <= mem[bus.ADDRESS];
            if (bus.WRITE_ENABLE) mem[bus.ADDRESS] <= bus.WRITE_DATA;
        end
    end

    typedef struct {
        int          due;
        logic        port;
        logic [31:0] data;
    } rsp_t;

    rsp_t        rsp_q[$];
    logic [31:0] ref_mem [1024];
    logic        last;
    int          cyc;
    bit          rmw_act;
    logic [9:0]  rmw_word;
    logic [31:0] rmw_old;

    logic        r_v   [2];
    logic [31:0] r_addr[2];
    logic        r_we  [2];
    logic [31:0] r_wd  [2];
    logic [3:0]  r_ws  [2];

    logic [31:0] obs_wd, obs_rd;
    logic [1:0]  obs_rdy;
    logic [3:0]  p1_seq;
    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] st);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) if (st[i]) m[8*i +: 8] = 8'hFF;
        return (nw & m) | (old & ~m);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic set_req(logic p, logic [31:0] a, logic we, logic [31:0] wd, logic [3:0] ws);
        r_v[p] = 1'b1; r_addr[p] = a; r_we[p] = we; r_wd[p] = wd; r_ws[p] = ws;
    endtask

    task automatic rand_req(logic p);
        logic [31:0] a;
        logic [3:0]  ws;
        a = $urandom();
        a[11:2] = ($urandom_range(0, 9) == 0) ? 10'h3FF : 10'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
            0:       ws = 4'hF;
            1:       ws = 4'h0;
            default: ws = 4'($urandom_range(1, 14));
        endcase
        set_req(p, a, 1'($urandom_range(0, 1)), $urandom(), ws);
    endtask

    task automatic apply();
        bus.P0_VALID = r_v[0]; bus.P0_ADDR = r_addr[0]; bus.P0_WE = r_we[0];
        bus.P0_WDATA = r_wd[0]; bus.P0_WSTRB = r_ws[0];
        bus.P1_VALID = r_v[1]; bus.P1_ADDR = r_addr[1]; bus.P1_WE = r_we[1];
        bus.P1_WDATA = r_wd[1]; bus.P1_WSTRB = r_ws[1];
    endtask

    // One clock: predict, compare at the falling edge, retire granted requests.
    task automatic tick();
        logic [1:0]  e_rdy;
        logic        e_en, e_we, e_r0, e_r1, g, g_v;
        logic [9:0]  e_addr, w;
        logic [31:0] e_wd, e_rd;
        rsp_t        r;
        apply();
        e_rdy = '0; e_en = 0; e_we = 0; e_r0 = 0; e_r1 = 0;
        e_addr = '0; e_wd = '0; e_rd = '0; g = 0; g_v = 0; w = '0;
        if (RST) begin
            if (rmw_act) ref_mem[rmw_word] = rmw_old;
            rmw_act = 0; last = 1'b1; rsp_q.delete();
        end else begin
            if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
                r = rsp_q.pop_front();
                e_r0 = (r.port == 1'b0); e_r1 = (r.port == 1'b1); e_rd = r.data;
            end
            if (rmw_act) begin
                e_en = 1; e_we = 1; e_addr = rmw_word; e_wd = ref_mem[rmw_word]; rmw_act = 0;
            end else if (r_v[0] || r_v[1]) begin
                g = (r_v[0] && r_v[1]) ? ~last : r_v[1];
                g_v = 1; last = g;
                e_rdy = g ? 2'b10 : 2'b01;
                w = r_addr[g][11:2];
                e_addr = w;
                if (!r_we[g]) begin
                    e_en = 1;
                    rsp_q.push_back('{due: cyc + 1, port: g, data: ref_mem[w]});
                end else if (r_ws[g] == 4'hF) begin
                    e_en = 1; e_we = 1; e_wd = r_wd[g]; ref_mem[w] = r_wd[g];
                    rsp_q.push_back('{due: cyc + 1, port: g, data: 32'h0});
                end else if (r_ws[g] == 4'h0) begin
                    rsp_q.push_back('{due: cyc + 1, port: g, data: 32'h0});
                end else begin
                    e_en = 1; rmw_act = 1; rmw_word = w; rmw_old = ref_mem[w];
                    ref_mem[w] = merge(ref_mem[w], r_wd[g], r_ws[g]);
                    rsp_q.push_back('{due: cyc + 2, port: g, data: 32'h0});
                end
            end
        end
        @(negedge CLK);
        chk("p0_ready", bus.P0_READY, e_rdy[0]);
        chk("p1_ready", bus.P1_READY, e_rdy[1]);
        chk("mem_en", bus.MEM_ENABLED, e_en);
        chk("wr_en", bus.WRITE_ENABLE, e_we);
        if (e_en) chk("address", bus.ADDRESS, e_addr);
        if (e_we) chk("write_data", bus.WRITE_DATA, e_wd);
        chk("p0_rsp", bus.P0_RSP_VALID, e_r0);
        chk("p1_rsp", bus.P1_RSP_VALID, e_r1);
        if (e_r0 || e_r1 || RST) chk("rsp_data", bus.RSP_DATA, e_rd);
        obs_wd  = bus.WRITE_DATA;
        obs_rd  = bus.RSP_DATA;
        obs_rdy = {bus.P1_READY, bus.P0_READY};
        @(posedge CLK);
        #1;
        cyc++;
        if (g_v) r_v[g] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i[9:0]] = '0;
        for (int p = 0; p < 2; p++) begin
            r_v[p] = 0; r_addr[p] = '0; r_we[p] = 0; r_wd[p] = '0; r_ws[p] = '0;
        end
        cyc = 0; last = 1'b1; rmw_act = 0; p1_seq = '0;

        // Reset; the memory is cleared while it is held.
        RST = 1; mem_clr = 1;
        tick(); tick();
        RST = 0; mem_clr = 0;

        // Full write by port 1, then read-back by port 0 on the next cycle.
        set_req(1'b1, 32'h10, 1'b1, 32'hDEADBEEF, 4'hF); tick();
        set_req(1'b0, 32'h10, 1'b0, 32'h0, 4'h0); tick();
        tick();
        chk("t1_rd_data", obs_rd, 32'hDEADBEEF);
        chk("t1_mem4", mem[4], 32'hDEADBEEF);

        // Four cycles of conflicting reads alternate 0,1,0,1.
        set_req(1'b1, 32'h20, 1'b0, 32'h0, 4'h0); tick();
        for (int n = 0; n < 4; n++) begin
            set_req(1'b0, 32'h10, 1'b0, 32'h0, 4'h0);
            set_req(1'b1, 32'h20, 1'b0, 32'h0, 4'h0);
            tick();
            p1_seq[n] = obs_rdy[1];
            chk("t2_one_ready", 32'(obs_rdy[0] ^ obs_rdy[1]), 32'h1);
        end
        r_v[0] = 0; r_v[1] = 0;
        chk("t2_grant_seq", p1_seq, 4'b1010);
        tick(); tick();

        // Partial store to 0xDEADBEEF, then a read of the merged word.
        set_req(1'b1, 32'h10, 1'b1, 32'h11223344, 4'b0101); tick();
        set_req(1'b0, 32'h10, 1'b0, 32'h0, 4'h0); tick();
        chk("t3_rmw_wdata", obs_wd, 32'hDE22BE44);
        chk("t3_rmw_ready", obs_rdy, 2'b00);
        tick(); tick();
        chk("t3_rd_merged", obs_rd, 32'hDE22BE44);

        // Read, partial store and read interleaved across the two ports.
        set_req(1'b1, 32'h18, 1'b1, 32'h0BADF00D, 4'hF); tick();
        set_req(1'b0, 32'h14, 1'b0, 32'h0, 4'h0);
        set_req(1'b1, 32'h14, 1'b1, 32'hA5A5A5A5, 4'b0011); tick();
        chk("t4_p0_first", obs_rdy, 2'b01);
        set_req(1'b0, 32'h14, 1'b0, 32'h0, 4'h0); tick();
        tick();
        chk("t4_p0_waits", obs_rdy, 2'b00);
        tick(); tick();
        chk("t4_rd_merged", obs_rd, 32'h0000A5A5);

        // Empty-strobe write leaves memory untouched.
        set_req(1'b0, 32'h10, 1'b1, 32'hFFFFFFFF, 4'h0); tick();
        tick();
        chk("t5_mem4", mem[4], 32'hDE22BE44);

        // Reset landing on the merge cycle drops the write and its response.
        set_req(1'b0, 32'h10, 1'b1, 32'hAA000000, 4'b1000); tick();
        RST = 1; tick(); RST = 0;
        set_req(1'b0, 32'h20, 1'b0, 32'h0, 4'h0);
        set_req(1'b1, 32'h24, 1'b0, 32'h0, 4'h0); tick();
        chk("t6_p0_wins", obs_rdy, 2'b01);
        tick(); tick();
        chk("t6_mem4", mem[4], 32'hDE22BE44);

        // Random traffic with held requests and occasional resets.
        for (int n = 0; n < 800; n++) begin
            if (!r_v[0] && $urandom_range(0, 99) < 60) rand_req(1'b0);
            if (!r_v[1] && $urandom_range(0, 99) < 60) rand_req(1'b1);
            RST = ($urandom_range(0, 99) == 0);
            tick();
        end
        RST = 0; r_v[0] = 0; r_v[1] = 0;
        tick(); tick(); tick();
        for (int i = 0; i < 8; i++) chk("final_mem", mem[i[9:0]], ref_mem[i[9:0]]);
        chk("final_mem_top", mem[1023], ref_mem[1023]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
